// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver: oversampling factor, receiver
// state encoding and the baud-tick divider computation.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

   // Each serial bit is split into this many sample ticks.
   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      WAIT_HIGH = 3'd0,
      IDLE      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4
   } state_t;

   // System clocks per sample tick, truncated.
   function automatic int calc_divider(input int clk_frequency, input int uart_frequency);
      return clk_frequency / (uart_frequency * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// -----------------------------------------------------------------------------
// uart_rx_tick
// Sample-tick generator: a counter running 0..DIVIDER-1 that flags the last
// count with a one-cycle tick. Clearing it realigns tick phase to a start edge.
//
// Ports
//   clock  in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   restart the count from 0 on the next edge
//   tick   out  high for one cycle when the count is DIVIDER-1
// -----------------------------------------------------------------------------
module uart_rx_tick #(
   parameter int DIVIDER = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 16x oversampling UART receiver (start bit, DATA_SIZE data bits LSB first,
// one stop bit) with a single-entry holding register and valid/ready handoff.
//
// Ports
//   i_clock       in   system clock
//   i_reset       in   synchronous active-high reset
//   i_rx          in   asynchronous serial line, idle high
//   i_ready       in   consumer takes o_data when high together with o_valid
//   o_data        out  held received word
//   o_valid       out  holding register full
//   o_frameError  out  one-cycle pulse: stop bit sampled low
//   o_overrun     out  one-cycle pulse: completed word dropped, holder full
//   o_busy        out  a frame is being received (START, DATA, STOP)
// -----------------------------------------------------------------------------
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQUENCY  = 100_000_000,
   parameter int UART_FREQUENCY = 9_200,
   parameter int DATA_SIZE      = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_rx,
   input  logic                 i_ready,
   output logic [DATA_SIZE-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frameError,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int DIVIDER = calc_divider(CLK_FREQUENCY, UART_FREQUENCY);
   localparam int BW      = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_SIZE - 1);

   if (DIVIDER < 2) begin : g_bad_divider
      $error("uart_rx: clock too slow for 16x oversampling (DIVIDER < 2)");
   end

   state_t               state;
   state_t               next_state;
   logic                 rx_meta;
   logic                 rx_sync;
   logic [1:0]           primed;
   logic                 tick;
   logic                 start_det;
   logic [3:0]           sample_cnt;
   logic [BW-1:0]        bit_cnt;
   logic                 samp7;
   logic                 samp8;
   logic                 majority;
   logic                 mid_tick;
   logic                 last_tick;
   logic [DATA_SIZE-1:0] shift;
   logic                 load;
   logic                 frame_err;
   logic                 overrun;

   // Two-flop synchronizer. The reset value 1 is not a real observation of the
   // line, so `primed` marks when rx_sync has been refilled from i_rx; without
   // it a line held low through reset would look high for a cycle and the
   // receiver would leave WAIT_HIGH and start on a line that never went idle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         primed  <= 2'b00;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         primed  <= {primed[0], 1'b1};
      end
   end

   assign start_det = (state == IDLE) && !rx_sync;

   uart_rx_tick #(
      .DIVIDER(DIVIDER)
   ) u_tick (
      .clock(i_clock),
      .reset(i_reset),
      .clear(start_det),
      .tick (tick)
   );

   assign mid_tick  = tick && (sample_cnt == 4'd9);
   assign last_tick = tick && (sample_cnt == 4'd15);
   // Ticks 7 and 8 are latched; tick 9 uses the live synchronized line.
   assign majority  = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);

   always_ff @(posedge i_clock) begin
      if (i_reset || start_det) begin
         sample_cnt <= '0;
         bit_cnt    <= '0;
      end else if (tick) begin
         sample_cnt <= sample_cnt + 4'd1;
         if (sample_cnt == 4'd15 && state == DATA) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         samp7 <= 1'b1;
         samp8 <= 1'b1;
         shift <= '0;
      end else begin
         if (tick && sample_cnt == 4'd7) samp7 <= rx_sync;
         if (tick && sample_cnt == 4'd8) samp8 <= rx_sync;
         if (state == DATA && mid_tick) shift <= {majority, shift[DATA_SIZE-1:1]};
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= WAIT_HIGH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      frame_err  = 1'b0;
      overrun    = 1'b0;
      case (state)
         WAIT_HIGH: if (primed[1] && rx_sync) next_state = IDLE;
         IDLE:      if (!rx_sync) next_state = START;
         START: begin
            if (mid_tick && majority) next_state = IDLE;
            else if (last_tick)       next_state = DATA;
         end
         DATA:      if (last_tick && bit_cnt == LAST_BIT) next_state = STOP;
         STOP: begin
            // Decided mid stop bit so the next start edge is never missed.
            if (mid_tick) begin
               if (majority) begin
                  next_state = IDLE;
                  if (!o_valid || i_ready) load = 1'b1;
                  else                     overrun = 1'b1;
               end else begin
                  next_state = WAIT_HIGH;
                  frame_err  = 1'b1;
               end
            end
         end
         default:   next_state = WAIT_HIGH;
      endcase
   end

   // Holding register: a load on the same edge as an accept keeps o_valid high.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frameError <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_frameError <= frame_err;
         o_overrun    <= overrun;
         if (load) begin
            o_data  <= shift;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (state == START) || (state == DATA) || (state == STOP);

endmodule
